// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU word port and physical-memory line port of the cache controller
interface cache_ctrl_if #(parameter int LINE_W = 128);
  logic              mem_read;
  logic              mem_write;
  logic [15:0]       mem_address;
  logic [1:0]        mem_byte_enable;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [15:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  modport master (
    output mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport slave (
    input  mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back write-allocate cache between the CPU word port and line memory
module cache_ctrl #(
  parameter int SETS   = 8,
  parameter int LINE_W = 128
) (
  input logic         clk,
  input logic         reset,
  cache_ctrl_if.slave bus
);
  localparam int OW = $clog2(LINE_W / 8);
  localparam int IW = $clog2(SETS);
  localparam int TW = 16 - OW - IW;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t            state, next;
  logic [LINE_W-1:0] data [SETS];
  logic [TW-1:0]     tags [SETS];
  logic [SETS-1:0]   valid, dirty;
  logic [TW-1:0]     tag;
  logic [IW-1:0]     idx;
  logic [OW-2:0]     ws;
  logic [15:0]       cur;
  logic              req, hit;
  assign tag = bus.mem_address[15 -: TW];
  assign idx = bus.mem_address[OW +: IW];
  assign ws  = bus.mem_address[OW-1:1];
  assign req = bus.mem_read | bus.mem_write;
  assign hit = valid[idx] && tags[idx] == tag;
  assign cur = data[idx][{ws, 4'b0} +: 16];
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE      ? (req && !hit ? (dirty[idx] ? WRITEBACK : FILL) : IDLE) :
           state == WRITEBACK ? (bus.pmem_resp ? FILL : WRITEBACK) :
                                (bus.pmem_resp ? IDLE : FILL);
  always_comb begin
    bus.mem_resp     = state == IDLE && req && hit;
    bus.mem_rdata    = bus.mem_resp ? cur : '0;
    bus.pmem_write   = state == WRITEBACK;
    bus.pmem_read    = state == FILL;
    bus.pmem_address = state == WRITEBACK ? {tags[idx], idx, OW'(0)} :
                       state == FILL      ? {bus.mem_address[15:OW], OW'(0)} : '0;
    bus.pmem_wdata   = state == WRITEBACK ? data[idx] : '0;
  end
  // a disabled lane keeps its old byte, yet any write hit marks the line dirty
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < SETS; i++) begin
        data[i] <= '0;
        tags[i] <= '0;
      end
      valid <= '0;
      dirty <= '0;
    end else if (bus.mem_resp && bus.mem_write) begin
      data[idx][{ws, 4'b0} +: 16] <= {bus.mem_byte_enable[1] ? bus.mem_wdata[15:8] : cur[15:8],
                                      bus.mem_byte_enable[0] ? bus.mem_wdata[7:0]  : cur[7:0]};
      dirty[idx] <= 1'b1;
    end else if (state == WRITEBACK && bus.pmem_resp) begin
      dirty[idx] <= 1'b0;
    end else if (state == FILL && bus.pmem_resp) begin
      data[idx]  <= bus.pmem_rdata;
      tags[idx]  <= tag;
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and random checks of cache_ctrl against a line-memory model
module tb_cache_ctrl;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  cache_ctrl_if bus();
  cache_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic [127:0] pmem [4096];
  logic [127:0] refm [4096];
  bit both_seen = 0;
  bit wb_seen, fill_seen;
  logic [15:0] wb_addr, fill_addr, rd;
  logic [127:0] wb_data;
  int cyc;
  localparam logic [127:0] LINE04  = 128'h0011_2233_4455_6677_8899_AABB_0123_4567;
  localparam logic [127:0] LINE04M = 128'h0011_2233_4455_6677_88EF_AABB_0123_4567;
  localparam logic [127:0] LINE44  = 128'hCAFE_0007_0006_0005_0004_0003_0002_0001;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one CPU request at posedge+1, act as line memory with fixed latency, return at posedge+1
  task automatic access(input bit wr, input logic [15:0] a, input logic [1:0] be,
                        input logic [15:0] wd, input int lat);
    int pend = 0;
    bit done = 0;
    cyc = 0; wb_seen = 0; fill_seen = 0; rd = '0;
    wb_addr = '0; fill_addr = '0; wb_data = '0;
    bus.mem_read = !wr; bus.mem_write = wr; bus.mem_address = a;
    bus.mem_byte_enable = be; bus.mem_wdata = wd;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (bus.pmem_read && bus.pmem_write) both_seen = 1;
      if (bus.mem_resp) begin
        rd = bus.mem_rdata;
        done = 1;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (bus.pmem_write && !wb_seen) begin
          wb_seen = 1; wb_addr = bus.pmem_address; wb_data = bus.pmem_wdata;
        end
        if (bus.pmem_read && !fill_seen) begin
          fill_seen = 1; fill_addr = bus.pmem_address;
        end
        pend++;
        if (pend == lat) begin
          pend = 0;
          bus.pmem_resp = 1;
          if (bus.pmem_write) pmem[bus.pmem_address[15:4]] = bus.pmem_wdata;
          else bus.pmem_rdata = pmem[bus.pmem_address[15:4]];
        end
      end
      @(posedge clk);
      #1;
      bus.pmem_resp = 0;
    end
    bus.mem_read = 0;
    bus.mem_write = 0;
    check("done", done, 1);
  endtask

  task automatic rand_access();
    logic [15:0] a;
    logic [127:0] l;
    logic [15:0] w, wd;
    logic [1:0] be;
    bit wr;
    a = {9'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 1'($urandom)};
    wr = 1'($urandom);
    be = 2'($urandom);
    wd = 16'($urandom);
    access(wr, a, be, wd, $urandom_range(1, 3));
    l = refm[a[15:4]];
    w = l[{a[3:1], 4'b0} +: 16];
    if (wr) begin
      if (be[1]) w[15:8] = wd[15:8];
      if (be[0]) w[7:0] = wd[7:0];
      l[{a[3:1], 4'b0} +: 16] = w;
      refm[a[15:4]] = l;
    end else check("rand_rd", rd, w);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      pmem[i] = {4{16'(i), 16'(i) ^ 16'hA5A5}};
    pmem[12'h004] = LINE04;
    pmem[12'h044] = LINE44;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = 0;
    bus.mem_byte_enable = 0; bus.mem_wdata = 0;
    bus.pmem_rdata = 0; bus.pmem_resp = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_mem_resp", bus.mem_resp, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_address", bus.pmem_address, 0);
    check("rst_pmem_wdata", bus.pmem_wdata, 0);
    @(posedge clk);
    #1;
    access(0, 16'h0040, 2'b00, 16'h0, 3);
    check("fill_rdata", rd, 16'h4567);
    check("fill_cycles", cyc, 5);
    check("fill_addr", fill_addr, 16'h0040);
    check("fill_no_wb", wb_seen, 0);
    access(1, 16'h0046, 2'b01, 16'hBEEF, 1);
    check("wr_hit_cycles", cyc, 1);
    access(0, 16'h0046, 2'b00, 16'h0, 1);
    check("rd_merged", rd, 16'h88EF);
    check("rd_hit_cycles", cyc, 1);
    access(0, 16'h0440, 2'b00, 16'h0, 2);
    check("evict_wb", wb_seen, 1);
    check("evict_wb_addr", wb_addr, 16'h0040);
    check("evict_wb_data", wb_data, LINE04M);
    check("evict_fill_addr", fill_addr, 16'h0440);
    check("evict_cycles", cyc, 6);
    check("evict_rdata", rd, 16'h0001);
    access(0, 16'h0440, 2'b00, 16'h0, 1);
    check("rehit_cycles", cyc, 1);
    check("rehit_no_pmem", {wb_seen, fill_seen}, 0);
    access(0, 16'h0040, 2'b00, 16'h0, 1);
    check("clean_evict_no_wb", wb_seen, 0);
    check("clean_evict_cycles", cyc, 3);
    check("clean_evict_rdata", rd, 16'h4567);
    access(1, 16'h0042, 2'b00, 16'hFFFF, 1);
    check("be00_cycles", cyc, 1);
    access(0, 16'h0442, 2'b00, 16'h0, 1);
    check("be00_dirty_wb", wb_seen, 1);
    check("be00_wb_data", wb_data, LINE04M);
    check("be00_cycles_miss", cyc, 4);
    check("be00_rdata", rd, 16'h0002);
    access(1, 16'h0443, 2'b10, 16'h5A00, 1);
    access(0, 16'h0442, 2'b00, 16'h0, 1);
    check("unaligned_rdata", rd, 16'h5A02);
    bus.mem_read = 1;
    bus.mem_address = 16'h0010;
    @(negedge clk);
    check("miss_idle_no_pmem", bus.pmem_read, 0);
    @(negedge clk);
    check("fill_req", bus.pmem_read, 1);
    reset = 1;
    bus.pmem_resp = 1;
    bus.pmem_rdata = '1;
    @(posedge clk);
    #1;
    reset = 0;
    bus.pmem_resp = 0;
    @(negedge clk);
    check("rst_fill_drop", bus.pmem_read, 0);
    check("rst_wb_drop", bus.pmem_write, 0);
    bus.mem_read = 0;
    @(posedge clk);
    #1;
    access(0, 16'h0440, 2'b00, 16'h0, 1);
    check("post_rst_miss", fill_seen, 1);
    check("post_rst_no_wb", wb_seen, 0);
    check("post_rst_cycles", cyc, 3);
    check("post_rst_rdata", rd, 16'h0001);
    for (int i = 0; i < 4096; i++) refm[i] = pmem[i];
    for (int n = 0; n < 2000; n++) rand_access();
    check("pmem_exclusive", both_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
